// File: rtl/intmult_arbiter.sv
// intmult_arbiter: round-robin arbiter feeding a shared pipelined multiplier and routing tagged results back.
// Define INTMULT_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins contention).
module intmult_arbiter #(
  parameter int DATA_W = 32,
  parameter int LAT = 3,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic                req1_valid,
  output logic                req0_ready,
  output logic                req1_ready,
  input  logic [DATA_W-1:0]   req0_a,
  input  logic [DATA_W-1:0]   req0_b,
  input  logic [DATA_W-1:0]   req1_a,
  input  logic [DATA_W-1:0]   req1_b,
  input  logic [TAG_W-1:0]    req0_tag,
  input  logic [TAG_W-1:0]    req1_tag,
  input  logic                hold,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic [2*DATA_W-1:0] mul_c,
  output logic                rsp0_valid,
  output logic                rsp1_valid,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                busy
);
  typedef struct packed {
    logic             v;
    logic             id;
    logic [TAG_W-1:0] tag;
  } stage_t;
  stage_t [LAT:0] pipe;
  logic open, g0, g1;
  assign open = !reset && !hold;
`ifdef INTMULT_ARB_FIXED_PRIO_EN
  assign g0 = open && req0_valid;
  assign g1 = open && req1_valid && !req0_valid;
`else
  logic last;
  assign g0 = open && req0_valid && (!req1_valid || last);
  assign g1 = open && req1_valid && (!req0_valid || !last);
  // last=1 means requester 1 was granted most recently, so reset favours requester 0
  always_ff @(posedge clk)
    if (reset) last <= 1'b1;
    else if (g0 || g1) last <= g1;
`endif
  assign req0_ready = g0;
  assign req1_ready = g1;
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a <= '0;
      mul_b <= '0;
      pipe  <= '0;
    end else begin
      mul_a <= g0 ? req0_a : g1 ? req1_a : '0;
      mul_b <= g0 ? req0_b : g1 ? req1_b : '0;
      pipe  <= {pipe[LAT-1:0], stage_t'{g0 || g1, g1, g0 ? req0_tag : g1 ? req1_tag : '0}};
    end
  end
  assign rsp0_valid = pipe[LAT].v && !pipe[LAT].id;
  assign rsp1_valid = pipe[LAT].v && pipe[LAT].id;
  assign rsp_data   = pipe[LAT].v ? mul_c : '0;
  assign rsp_tag    = pipe[LAT].v ? pipe[LAT].tag : '0;
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= LAT; i++) busy = busy | pipe[i].v;
  end
endmodule

// File: tb/tb_intmult_arbiter.sv
// tb_intmult_arbiter: directed self-checking bench with a 3-stage multiplier model.
module tb_intmult_arbiter;
  logic clk = 0, reset = 1, hold = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, mul_a, mul_b;
  logic [3:0] req0_tag = 0, req1_tag = 0, rsp_tag;
  logic [63:0] mul_c = 0, p1 = 0, p2 = 0, rsp_data;
  logic rsp0_valid, rsp1_valid, busy;
  int tests = 0, fails = 0;

  intmult_arbiter #(.DATA_W(32), .LAT(3), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_a(req1_a), .req1_b(req1_b), .req0_tag(req0_tag), .req1_tag(req1_tag), .hold(hold),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    p1 <= 64'(mul_a) * 64'(mul_b);
    p2 <= p1;
    mul_c <= p2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0; hold = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_tag = 0; req1_tag = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    req0_valid = 1; req1_valid = 1;
    #2;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready});
    end
    tick();
    idle();
    tick();
    reset = 0;
    #2;
    tests++;
    if ({mul_a, mul_b} !== 64'd0 || {rsp0_valid, rsp1_valid, busy} !== 3'b000 || rsp_data !== 64'd0 || rsp_tag !== 4'd0) begin
      fails++; $display("FAIL reset_state got mul_a=%h mul_b=%h v=%b%b busy=%b data=%h tag=%h exp all 0",
                        mul_a, mul_b, rsp0_valid, rsp1_valid, busy, rsp_data, rsp_tag);
    end
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1; req0_a = 3; req0_b = 5; req0_tag = 1;
    #2;
    tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL single_ready got %b%b exp 10", req0_ready, req1_ready);
    end
    tick();
    idle();
    for (int c = 1; c <= 6; c++) begin
      #2;
      tests++;
      if (busy !== (c <= 4) || rsp0_valid !== (c == 4) || rsp1_valid !== 1'b0) begin
        fails++; $display("FAIL single_flags c=%0d got busy=%b v0=%b v1=%b exp busy=%b v0=%b v1=0",
                          c, busy, rsp0_valid, rsp1_valid, c <= 4, c == 4);
      end
      tests++;
      if (rsp_data !== ((c == 4) ? 64'd15 : 64'd0) || rsp_tag !== ((c == 4) ? 4'd1 : 4'd0)) begin
        fails++; $display("FAIL single_data c=%0d got data=%0d tag=%0d exp data=%0d tag=%0d",
                          c, rsp_data, rsp_tag, (c == 4) ? 15 : 0, (c == 4) ? 1 : 0);
      end
      tests++;
      if (mul_a !== ((c == 1) ? 32'd3 : 32'd0) || mul_b !== ((c == 1) ? 32'd5 : 32'd0)) begin
        fails++; $display("FAIL single_mul c=%0d got a=%0d b=%0d exp a=%0d b=%0d",
                          c, mul_a, mul_b, (c == 1) ? 3 : 0, (c == 1) ? 5 : 0);
      end
      tick();
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_v   [4:8] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
    logic [63:0] exp_dat [4:8] = '{64'd30, 64'd56, 64'd33, 64'd63, 64'd0};
    logic [3:0]  exp_tag [4:8] = '{4'd0, 4'd8, 4'd1, 4'd9, 4'd0};
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      if (c <= 3) begin
        req0_valid = 1; req1_valid = 1;
        req0_tag = 4'(c >> 1); req1_tag = 4'(8 + (c >> 1));
        req0_a = 32'(10 + (c >> 1)); req0_b = 3;
        req1_a = 32'(8 + (c >> 1)); req1_b = 7;
      end else idle();
      #2;
      if (c <= 3) begin
        tests++;
        if ({req0_ready, req1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
          fails++; $display("FAIL contention_grant c=%0d got %b%b exp %b", c, req0_ready, req1_ready,
                            (c % 2 == 0) ? 2'b10 : 2'b01);
        end
      end else begin
        tests++;
        if ({rsp0_valid, rsp1_valid} !== exp_v[c] || rsp_data !== exp_dat[c] || rsp_tag !== exp_tag[c]) begin
          fails++; $display("FAIL contention_rsp c=%0d got v=%b%b data=%0d tag=%0d exp v=%b data=%0d tag=%0d",
                            c, rsp0_valid, rsp1_valid, rsp_data, rsp_tag, exp_v[c], exp_dat[c], exp_tag[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    for (int c = 0; c <= 2; c++) begin
      req0_valid = 1; req1_valid = 1;
      #2;
      tests++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
        fails++; $display("FAIL fixed_prio c=%0d got %b%b exp 10", c, req0_ready, req1_ready);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_max();
    do_reset();
    req1_valid = 1; req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF; req1_tag = 3;
    tick();
    idle();
    tick(); tick(); tick();
    #2;
    tests++;
    if (rsp1_valid !== 1'b1 || rsp_data !== 64'hFFFF_FFFE_0000_0001 || rsp_tag !== 4'd3) begin
      fails++; $display("FAIL max_operands got v1=%b data=%h tag=%0d exp v1=1 data=fffffffe00000001 tag=3",
                        rsp1_valid, rsp_data, rsp_tag);
    end
  endtask

  task automatic test_hold();
    do_reset();
    req1_valid = 1; req1_a = 7; req1_b = 6; req1_tag = 5;
    #2;
    tests++;
    if (req1_ready !== 1'b1) begin
      fails++; $display("FAIL hold_pregrant got %b exp 1", req1_ready);
    end
    tick();
    for (int c = 0; c <= 6; c++) begin
      req0_valid = 1; req1_valid = 1; hold = (c < 5);
      req0_a = 2; req0_b = 2; req0_tag = 2; req1_tag = 6;
      #2;
      tests++;
      if (req0_ready !== (c == 5) || req1_ready !== (c == 6)) begin
        fails++; $display("FAIL hold_grant c=%0d got %b%b exp %b%b", c, req0_ready, req1_ready, c == 5, c == 6);
      end
      tests++;
      if (rsp1_valid !== (c == 3) || rsp0_valid !== 1'b0 || rsp_data !== ((c == 3) ? 64'd42 : 64'd0)) begin
        fails++; $display("FAIL hold_inflight c=%0d got v0=%b v1=%b data=%0d exp v0=0 v1=%b data=%0d",
                          c, rsp0_valid, rsp1_valid, rsp_data, c == 3, (c == 3) ? 42 : 0);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1; req1_valid = 1; req0_a = 2; req0_b = 2; req1_a = 3; req1_b = 3;
    #2;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++; $display("FAIL mid_grant0 got %b%b exp 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 0;
    #2;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      fails++; $display("FAIL mid_grant1 got %b%b exp 01", req0_ready, req1_ready);
    end
    tick();
    reset = 1; req0_valid = 1;
    #2;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b00 || busy !== 1'b1) begin
      fails++; $display("FAIL mid_reset_cycle got ready=%b%b busy=%b exp ready=00 busy=1", req0_ready, req1_ready, busy);
    end
    tick();
    reset = 0;
    idle();
    for (int c = 3; c <= 8; c++) begin
      #2;
      tests++;
      if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
        fails++; $display("FAIL mid_dropped c=%0d got v0=%b v1=%b busy=%b exp 0 0 0", c, rsp0_valid, rsp1_valid, busy);
      end
      tick();
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_single();
`ifdef INTMULT_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_contention();
`endif
    test_max();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
